timed_chip: RTL and testbench
=============================

Name: timed_chip

Overview:
- Successor to the bank-group chip model: a parametrised DRAM chip model whose per-bank state and timing are kept inside the chip instead of at the controller.
- Accepts a single narrow command stream (ACT/RD/WR/PRE, optional REF) addressed by bank group and bank.
- Tracks the open row per bank, enforces tRCD/tRP, and returns read data after a fixed CAS latency.
- Sits under the rank/DIMM model in place of the wide per-bank-array interface.

Parameters:
BGWIDTH, 2, bank-group address width
BANKGROUPS, 2**BGWIDTH, bank groups (set to 1 for DDR3 and earlier)
BAWIDTH, 2, bank address width within a group
BANKSPERGROUP, 2**BAWIDTH, banks per group
COLWIDTH, 10, column address width
CHWIDTH, 5, row address width
DEVICE_WIDTH, 4, data bits per access
TRCD, 3, ACT-to-RD/WR cycles (>=1)
TRP, 3, PRE-to-ACT cycles (>=1)
CL, 4, RD-accept-to-rdata cycles (>=1)
TRFC, 8, refresh busy cycles (>=1; used only with CHIP_REFRESH_EN)

Ports:
clk  in  1  clock
reset_n  in  1  synchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted this cycle when high with cmd_valid
cmd  in  3  chip_pkg::cmd_e: NOP=0, ACT=1, RD=2, WR=3, PRE=4, REF=5
bg  in  max(BGWIDTH,1)  target bank group
ba  in  BAWIDTH  target bank
row  in  CHWIDTH  row, sampled on ACT
column  in  COLWIDTH  column, sampled on RD/WR
dqin  in  DEVICE_WIDTH  write data, sampled with WR
dqout  out  DEVICE_WIDTH  read data
rvalid  out  1  dqout valid
cmd_err  out  1  one-cycle pulse: accepted command illegal for target state

Behaviour:
- One clock (clk). Reset is synchronous and active-low (reset_n).
- While reset_n=0 at an edge:
  - all banks go to IDLE; counters, open-row registers and the read pipeline clear.
  - Outputs: dqout=0, rvalid=0, cmd_err=0.
  - Storage contents are not cleared.
  - Reset mid-ACT/PRE/read abandons the operation; no rvalid follows.
- Accept condition: cmd_valid & cmd_ready at a rising edge. NOP is always accepted with no effect.
- Bank FSM, per bank: IDLE, ACTIVATING, ACTIVE, PRECHARGING.
  - IDLE --ACT--> ACTIVATING: latch row; counter loads TRCD-1.
  - ACTIVATING --counter==0--> ACTIVE. A bank activated at edge N accepts RD/WR at edge N+TRCD.
  - ACTIVE --PRE--> PRECHARGING: counter loads TRP-1. Back to IDLE so that ACT is accepted at edge N+TRP.
  - With TRCD=1 or TRP=1 the transitional state lasts exactly one cycle.
- cmd_ready is combinational: 0 iff the addressed bank is ACTIVATING or PRECHARGING (or a refresh is in progress); otherwise 1. Other banks keep counting independently.
- Legality:
  - ACT is legal only in IDLE.
  - RD and WR are legal only in ACTIVE.
  - PRE in IDLE is a legal no-op; PRE in ACTIVE is legal.
  - An illegal accepted command causes no state or memory change and cmd_err=1 in the following cycle.
- WR: memory[bank][open_row][column] <= dqin at the accepting edge.
- RD: memory is read at the accepting edge N; dqout/rvalid are valid in the cycle after edge N+CL-1, i.e. registered CL cycles later.
  - Back-to-back RDs give back-to-back rvalid.
  - A WR at edge N-1 is visible to a RD at N.
- Bank index = bg*BANKSPERGROUP + ba. Storage is BANKGROUPS*BANKSPERGROUP*2**CHWIDTH*2**COLWIDTH words.

Optional Feature:
- Macro CHIP_REFRESH_EN.
- When defined:
  - REF is legal only when all banks are IDLE; otherwise cmd_err.
  - A legal REF drops cmd_ready for all targets for TRFC cycles; the next command is accepted at edge N+TRFC.
  - Reset aborts a refresh.
- When undefined: REF, like codes 6-7, is treated as illegal (cmd_err) and cmd_ready ignores refresh.

Decomposition:
- Package chip_pkg: cmd_e enum, bank_state_e enum, bank index width function.
- Sub-module bank_fsm: one per bank via generate. It holds the state, timing counter and open-row register, and outputs busy/active/open_row.
- Top level: decode, legality, storage array, CL shift pipeline.

Test Plan:
- Reset, then ACT bg=1 ba=2 row=5 at edge 0: cmd_ready low for that bank through edge 2; RD col=7 retried and accepted at edge 3 (TRCD=3).
- WR bg=0 ba=0 row=3 col=0x3FF dq=0xA, then RD of the same address: rvalid high for one cycle exactly 4 cycles after the RD edge, dqout=0xA.
- RD to an IDLE bank: cmd_err pulses 1 cycle, no rvalid. ACT to an ACTIVE bank: cmd_err, open row unchanged.
- ACT bank0 and bank5 on consecutive edges; commands to bank5 stay serviceable while bank0 counts. PRE bank0, then ACT bank0 is accepted exactly TRP cycles later.
- Four back-to-back RDs col=0..3: four consecutive rvalid cycles carrying the matching data. Assert reset_n=0 after the second read edge: no further rvalid, all banks IDLE.
- CHIP_REFRESH_EN: REF with all banks IDLE drops cmd_ready for 8 cycles. REF with one bank ACTIVE gives cmd_err.

Source files
------------

// File: rtl/chip_pkg.sv
// Shared types for the timed DRAM chip model: command codes, per-bank states
// and the bank-index width helper.
package chip_pkg;

    localparam int CMD_W = 3;

    typedef enum logic [CMD_W-1:0] {
        CMD_NOP = 3'd0,
        CMD_ACT = 3'd1,
        CMD_RD  = 3'd2,
        CMD_WR  = 3'd3,
        CMD_PRE = 3'd4,
        CMD_REF = 3'd5
    } cmd_e;

    typedef enum logic [1:0] {
        BANK_IDLE        = 2'd0,
        BANK_ACTIVATING  = 2'd1,
        BANK_ACTIVE      = 2'd2,
        BANK_PRECHARGING = 2'd3
    } bank_state_e;

    function automatic int bank_idx_width(input int bgwidth, input int bawidth);
        return ((bgwidth + bawidth) > 0) ? (bgwidth + bawidth) : 1;
    endfunction

endpackage

// File: rtl/bank_fsm.sv
// One DRAM bank: state, tRCD/tRP countdown and open-row register.
// A transitional state whose counter has reached zero already behaves as its target state.
module bank_fsm
    import chip_pkg::*;
#(
    parameter int TRCD    = 3,
    parameter int TRP     = 3,
    parameter int CHWIDTH = 5
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               act_i,
    input  logic               pre_i,
    input  logic [CHWIDTH-1:0] row_i,
    output logic               busy_o,
    output logic               active_o,
    output logic [CHWIDTH-1:0] open_row_o
);

    localparam int MAXT = (TRCD > TRP) ? TRCD : TRP;
    localparam int CNTW = (MAXT > 1) ? $clog2(MAXT) : 1;
    localparam logic [CNTW-1:0] TRCD_LOAD = CNTW'(TRCD - 1);
    localparam logic [CNTW-1:0] TRP_LOAD  = CNTW'(TRP - 1);

    bank_state_e        state_q, state_d;
    logic [CNTW-1:0]    cnt_q, cnt_d;
    logic [CHWIDTH-1:0] row_q, row_d;
    logic               done_s;
    logic               idle_s;

    assign done_s     = (cnt_q == '0);
    assign active_o   = (state_q == BANK_ACTIVE) || ((state_q == BANK_ACTIVATING) && done_s);
    assign idle_s     = (state_q == BANK_IDLE) || ((state_q == BANK_PRECHARGING) && done_s);
    assign busy_o     = !active_o && !idle_s;
    assign open_row_o = row_q;

    // Next-state and countdown logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        row_d   = row_q;
        if (busy_o) begin
            cnt_d = cnt_q - CNTW'(1);
        end else if (active_o) begin
            if (pre_i) begin
                state_d = BANK_PRECHARGING;
                cnt_d   = TRP_LOAD;
            end else begin
                state_d = BANK_ACTIVE;
            end
        end else begin
            if (act_i) begin
                state_d = BANK_ACTIVATING;
                cnt_d   = TRCD_LOAD;
                row_d   = row_i;
            end else begin
                state_d = BANK_IDLE;
            end
        end
    end

    // State, counter and open-row registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= BANK_IDLE;
            cnt_q   <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
        end
    end

endmodule

// File: rtl/timed_chip.sv
// DRAM chip model with in-chip bank timing; command decode, storage and CAS pipeline.
// Optional refresh support is enabled with the CHIP_REFRESH_EN macro.
module timed_chip
    import chip_pkg::*;
#(
    parameter int BGWIDTH       = 2,
    parameter int BANKGROUPS    = 2**BGWIDTH,
    parameter int BAWIDTH       = 2,
    parameter int BANKSPERGROUP = 2**BAWIDTH,
    parameter int COLWIDTH      = 10,
    parameter int CHWIDTH       = 5,
    parameter int DEVICE_WIDTH  = 4,
    parameter int TRCD          = 3,
    parameter int TRP           = 3,
    parameter int CL            = 4,
    parameter int TRFC          = 8
) (
    input  logic                                      clk,
    input  logic                                      reset_n,
    input  logic                                      cmd_valid,
    output logic                                      cmd_ready,
    input  logic [2:0]                                cmd,
    input  logic [((BGWIDTH > 0) ? BGWIDTH : 1)-1:0]  bg,
    input  logic [BAWIDTH-1:0]                        ba,
    input  logic [CHWIDTH-1:0]                        row,
    input  logic [COLWIDTH-1:0]                       column,
    input  logic [DEVICE_WIDTH-1:0]                   dqin,
    output logic [DEVICE_WIDTH-1:0]                   dqout,
    output logic                                      rvalid,
    output logic                                      cmd_err
);

    localparam int NBANKS = BANKGROUPS * BANKSPERGROUP;
    localparam int BIW    = bank_idx_width(BGWIDTH, BAWIDTH);
    localparam int AW     = BIW + CHWIDTH + COLWIDTH;
    localparam int RFW    = (TRFC > 1) ? $clog2(TRFC) : 1;
    localparam logic [RFW-1:0] TRFC_LOAD = RFW'(TRFC - 1);

    cmd_e                    cmd_s;
    logic [BIW-1:0]          bank_idx_s;
    logic [NBANKS-1:0]       busy_s, active_s, act_s, pre_s;
    logic [CHWIDTH-1:0]      open_row_s [NBANKS];
    logic [AW-1:0]           addr_s;
    logic                    accept_s, legal_s, all_idle_s, ref_busy_s;
    logic                    do_act_s, do_pre_s, do_rd_s, do_wr_s, do_ref_s;
    logic [RFW-1:0]          ref_cnt_q, ref_cnt_d;
    logic                    cmd_err_q;
    logic [DEVICE_WIDTH-1:0] mem_q [0:(2**AW)-1];
    logic                    rv_q [CL];
    logic [DEVICE_WIDTH-1:0] rd_q [CL];

    if (BGWIDTH == 0) begin : g_no_bg
        assign bank_idx_s = BIW'(ba);
    end else begin : g_bg
        assign bank_idx_s = BIW'({bg, ba});
    end

    assign cmd_s      = cmd_e'(cmd);
    assign all_idle_s = ~|(busy_s | active_s);
    assign ref_busy_s = (ref_cnt_q != '0);
    assign cmd_ready  = !ref_busy_s && !busy_s[bank_idx_s];
    assign accept_s   = cmd_valid && cmd_ready;
    assign addr_s     = {bank_idx_s, open_row_s[bank_idx_s], column};
    assign act_s      = (accept_s && do_act_s) ? (NBANKS'(1'b1) << bank_idx_s) : '0;
    assign pre_s      = (accept_s && do_pre_s) ? (NBANKS'(1'b1) << bank_idx_s) : '0;

    for (genvar g = 0; g < NBANKS; g++) begin : g_bank
        bank_fsm #(
            .TRCD    (TRCD),
            .TRP     (TRP),
            .CHWIDTH (CHWIDTH)
        ) u_bank (
            .clk        (clk),
            .reset_n    (reset_n),
            .act_i      (act_s[g]),
            .pre_i      (pre_s[g]),
            .row_i      (row),
            .busy_o     (busy_s[g]),
            .active_o   (active_s[g]),
            .open_row_o (open_row_s[g])
        );
    end

    // Command legality against the addressed bank's state
    always_comb begin
        legal_s  = 1'b0;
        do_act_s = 1'b0;
        do_pre_s = 1'b0;
        do_rd_s  = 1'b0;
        do_wr_s  = 1'b0;
        do_ref_s = 1'b0;
        case (cmd_s)
            CMD_NOP: legal_s = 1'b1;
            CMD_ACT: begin
                legal_s  = !active_s[bank_idx_s];
                do_act_s = !active_s[bank_idx_s];
            end
            CMD_RD: begin
                legal_s = active_s[bank_idx_s];
                do_rd_s = active_s[bank_idx_s];
            end
            CMD_WR: begin
                legal_s = active_s[bank_idx_s];
                do_wr_s = active_s[bank_idx_s];
            end
            // PRE to an idle bank is accepted as a no-op
            CMD_PRE: begin
                legal_s  = 1'b1;
                do_pre_s = active_s[bank_idx_s];
            end
`ifdef CHIP_REFRESH_EN
            CMD_REF: begin
                legal_s  = all_idle_s;
                do_ref_s = all_idle_s;
            end
`endif
            default: legal_s = 1'b0;
        endcase
    end

    // Refresh busy countdown
    always_comb begin
        ref_cnt_d = ref_cnt_q;
        if (accept_s && do_ref_s) begin
            ref_cnt_d = TRFC_LOAD;
        end else if (ref_busy_s) begin
            ref_cnt_d = ref_cnt_q - RFW'(1);
        end else begin
            ref_cnt_d = ref_cnt_q;
        end
    end

    // Refresh counter and error pulse
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ref_cnt_q <= '0;
            cmd_err_q <= 1'b0;
        end else begin
            ref_cnt_q <= ref_cnt_d;
            cmd_err_q <= accept_s && !legal_s;
        end
    end

    // Storage write port; contents survive reset
    always_ff @(posedge clk) begin
        if (reset_n && accept_s && do_wr_s) begin
            mem_q[addr_s] <= dqin;
        end
    end

    // CAS latency pipeline: stage 0 captures the array at the RD edge
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int k = 0; k < CL; k++) begin
                rv_q[k] <= 1'b0;
                rd_q[k] <= '0;
            end
        end else begin
            rv_q[0] <= accept_s && do_rd_s;
            rd_q[0] <= (accept_s && do_rd_s) ? mem_q[addr_s] : '0;
            for (int k = 1; k < CL; k++) begin
                rv_q[k] <= rv_q[k-1];
                rd_q[k] <= rd_q[k-1];
            end
        end
    end

    assign dqout   = rd_q[CL-1];
    assign rvalid  = rv_q[CL-1];
    assign cmd_err = cmd_err_q;

endmodule

// File: tb/tb_timed_chip.sv
// Scoreboard bench for timed_chip: a time-based bank model predicts readiness,
// errors and read data; a negedge monitor compares DUT outputs every cycle.
module tb_timed_chip;

    localparam int TRCD = 3;
    localparam int TRP  = 3;
    localparam int CL   = 4;
    localparam int TRFC = 8;
    localparam int NB   = 16;

    logic       clk = 1'b0;
    logic       reset_n, cmd_valid, cmd_ready, rvalid, cmd_err;
    logic [2:0] cmd;
    logic [1:0] bg, ba;
    logic [4:0] row;
    logic [9:0] column;
    logic [3:0] dqin, dqout;

    timed_chip #(
        .BGWIDTH(2), .BANKGROUPS(4), .BAWIDTH(2), .BANKSPERGROUP(4),
        .COLWIDTH(10), .CHWIDTH(5), .DEVICE_WIDTH(4),
        .TRCD(TRCD), .TRP(TRP), .CL(CL), .TRFC(TRFC)
    ) dut (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd(cmd), .bg(bg), .ba(ba), .row(row), .column(column), .dqin(dqin),
        .dqout(dqout), .rvalid(rvalid), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         due;
        bit         known;
        logic [3:0] data;
    } rd_exp_t;

    int         checks = 0;
    int         errors = 0;
    int         edge_cnt = 0;
    bit         mon_en = 1'b0;
    rd_exp_t    rdq[$];
    int         errq[$];
    bit         m_open[NB];
    int         m_row[NB];
    int         m_ready_at[NB];
    int         m_ref_at;
    logic [3:0] m_mem[int];
    int         pool[5] = '{0, 1, 5, 6, 15};
    bit         mon_exp_err, mon_exp_v;
    rd_exp_t    mon_e;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    function automatic bit m_ready(input int b, input int n);
        return (n >= m_ready_at[b]) && (n >= m_ref_at);
    endfunction

    function automatic bit m_all_idle(input int n);
        for (int i = 0; i < NB; i++) begin
            if (m_open[i] || (n < m_ready_at[i])) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Monitor: error pulses and read returns scheduled by the model
    always @(negedge clk) begin
        if (mon_en) begin
            mon_exp_err = (errq.size() > 0) && (errq[0] == edge_cnt);
            if (mon_exp_err) void'(errq.pop_front());
            chk("cmd_err", 32'(cmd_err), 32'(mon_exp_err));
            mon_exp_v = (rdq.size() > 0) && (rdq[0].due == edge_cnt);
            chk("rvalid", 32'(rvalid), 32'(mon_exp_v));
            if (mon_exp_v) begin
                mon_e = rdq.pop_front();
                if (mon_e.known && rvalid) chk("dqout", 32'(dqout), 32'(mon_e.data));
            end
        end
    end

    task automatic issue(input bit v, input int c, input int b, input int r, input int col,
                         input logic [3:0] d, output bit acc, output int n);
        bit      rdy, legal;
        int      key;
        rd_exp_t e;
        @(negedge clk);
        #1;
        cmd_valid = v; cmd = 3'(c); bg = 2'(b / 4); ba = 2'(b % 4);
        row = 5'(r); column = 10'(col); dqin = d;
        #1;
        n   = edge_cnt + 1;
        rdy = m_ready(b, n);
        chk("cmd_ready", 32'(cmd_ready), 32'(rdy));
        acc = v && rdy;
        if (acc) begin
            legal = 1'b1;
            key   = b * 32768 + m_row[b] * 1024 + col;
            case (c)
                0: legal = 1'b1;
                1: if (!m_open[b]) begin
                       m_open[b] = 1'b1; m_row[b] = r; m_ready_at[b] = n + TRCD;
                   end else legal = 1'b0;
                2: if (m_open[b]) begin
                       e.due   = n + CL - 1;
                       e.known = m_mem.exists(key);
                       e.data  = e.known ? m_mem[key] : 4'd0;
                       rdq.push_back(e);
                   end else legal = 1'b0;
                3: if (m_open[b]) m_mem[key] = d; else legal = 1'b0;
                4: if (m_open[b]) begin
                       m_open[b] = 1'b0; m_ready_at[b] = n + TRP;
                   end
`ifdef CHIP_REFRESH_EN
                5: if (m_all_idle(n)) m_ref_at = n + TRFC; else legal = 1'b0;
`endif
                default: legal = 1'b0;
            endcase
            if (!legal) errq.push_back(n);
        end
    endtask

    task automatic issue_retry(input int c, input int b, input int r, input int col,
                               input logic [3:0] d);
        bit acc;
        int n, tries;
        acc = 1'b0;
        tries = 0;
        while (!acc && tries < 40) begin
            issue(1'b1, c, b, r, col, d, acc, n);
            tries++;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL retry_timeout: cmd %0d bank %0d never accepted", c, b);
        end
    endtask

    task automatic idle(input int cycles);
        bit acc;
        int n;
        for (int i = 0; i < cycles; i++) issue(1'b0, 0, 0, 0, 0, 4'd0, acc, n);
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        cmd_valid = 1'b0;
        rdq.delete();
        errq.delete();
        for (int i = 0; i < NB; i++) begin
            m_open[i] = 1'b0;
            m_ready_at[i] = 0;
        end
        m_ref_at = 0;
        repeat (cycles) @(posedge clk);
        @(negedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        bit acc;
        int n;
        logic [3:0] wd;
        reset_n = 1'b0; cmd_valid = 1'b0; cmd = 3'd0; bg = 2'd0; ba = 2'd0;
        row = 5'd0; column = 10'd0; dqin = 4'd0;
        for (int i = 0; i < NB; i++) m_row[i] = 0;
        do_reset(3);
        mon_en = 1'b1;
        chk("reset_dqout", 32'(dqout), 32'd0);
        chk("reset_rvalid", 32'(rvalid), 32'd0);
        for (int b = 0; b < NB; b++) issue(1'b0, 0, b, 0, 0, 4'd0, acc, n);

        // ACT bg1/ba2 then RD retried until tRCD elapses
        issue(1'b1, 1, 6, 5, 0, 4'd0, acc, n);
        issue_retry(2, 6, 0, 7, 4'd0);
        // write then read back the same address
        issue(1'b1, 1, 0, 3, 0, 4'd0, acc, n);
        issue_retry(3, 0, 0, 10'h3FF, 4'hA);
        issue(1'b1, 2, 0, 0, 10'h3FF, 4'd0, acc, n);
        idle(CL + 1);
        // illegal commands: RD to idle bank, ACT to active bank
        issue(1'b1, 2, 9, 0, 1, 4'd0, acc, n);
        issue(1'b1, 1, 0, 7, 0, 4'd0, acc, n);
        issue(1'b1, 2, 0, 0, 10'h3FF, 4'd0, acc, n);
        idle(CL + 1);
        // PRE/ACT timing with an independent bank in between
        issue(1'b1, 4, 0, 0, 0, 4'd0, acc, n);
        issue(1'b1, 1, 5, 1, 0, 4'd0, acc, n);
        issue_retry(1, 0, 3, 0, 4'd0);
        issue_retry(3, 5, 0, 9, 4'h5);
        issue(1'b1, 2, 5, 0, 9, 4'd0, acc, n);
        // four back-to-back reads
        for (int c = 0; c < 4; c++) begin
            wd = 4'($urandom_range(0, 15));
            issue_retry(3, 0, 0, c, wd);
        end
        for (int c = 0; c < 4; c++) issue(1'b1, 2, 0, 0, c, 4'd0, acc, n);
        idle(CL + 2);
        // reset in the middle of a read burst
        issue(1'b1, 2, 0, 0, 0, 4'd0, acc, n);
        issue(1'b1, 2, 0, 0, 1, 4'd0, acc, n);
        do_reset(2);
        for (int b = 0; b < NB; b++) issue(1'b0, 0, b, 0, 0, 4'd0, acc, n);
        idle(CL + 2);
        // refresh (illegal when the feature is compiled out)
        issue(1'b1, 5, 0, 0, 0, 4'd0, acc, n);
        idle(TRFC + 1);
        issue_retry(1, 3, 0, 0, 4'd0);
        idle(TRCD);
        issue(1'b1, 5, 0, 0, 0, 4'd0, acc, n);
        issue(1'b1, 6, 0, 0, 0, 4'd0, acc, n);
        issue(1'b1, 7, 3, 0, 0, 4'd0, acc, n);
        issue_retry(4, 3, 0, 0, 4'd0);
        idle(TRP + 1);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int sel, b, c;
            bit v;
            sel = $urandom_range(0, 15);
            b   = pool[$urandom_range(0, 4)];
            v   = ($urandom_range(0, 9) != 0);
            if (sel < 2)       c = 0;
            else if (sel < 5)  c = 1;
            else if (sel < 9)  c = 2;
            else if (sel < 12) c = 3;
            else if (sel < 14) c = 4;
            else if (sel < 15) c = 5;
            else               c = $urandom_range(6, 7);
            if ($urandom_range(0, 599) == 0) begin
                do_reset(2);
            end else begin
                issue(v, c, b, $urandom_range(0, 3), $urandom_range(0, 7),
                      4'($urandom_range(0, 15)), acc, n);
            end
        end
        idle(CL + 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
